// File: rtl/wb_bank_streamer.sv
// Multi-bank weight/bias RAM with a serial interleaved loader and a parallel read streamer (WB_INIT_FROM_HEX_EN marks the banks as preloaded).
// Latency: the first vector is valid 2 cycles after rd_start, then 1 vector/cycle.
// Backpressure: a 2-entry output buffer holds q/q_addr while stalled; loading is blocked while a read is busy.
module wb_bank_streamer #(
  parameter int NUM_BANKS = 20,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_full,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_len,
  output logic              rd_busy,
  output logic              rd_done,
  output logic              q_valid,
  input  logic              q_ready,
  output logic [DATA_W-1:0] q [NUM_BANKS],
  output logic [ADDR_W-1:0] q_addr
);

  localparam int LANE_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

`ifdef WB_INIT_FROM_HEX_EN
  localparam logic FULL_RST = 1'b1;
`else
  localparam logic FULL_RST = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state_q, state_d;

  logic              rst_done;
  logic [LANE_W-1:0] lane_ptr;
  logic [ADDR_W-1:0] addr_ptr;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   rem;
  logic              issue;
  logic              pop;
  logic [DATA_W-1:0] mem_out [NUM_BANKS];
  logic [DATA_W-1:0] slot [2][NUM_BANKS];
  logic [ADDR_W-1:0] slot_addr [2];
  logic              wr_sel;
  logic              rd_sel;
  logic [1:0]        count;

  assign rd_busy  = (state_q == READ) || (state_q == DRAIN);
  assign ld_ready = rst_done && !rd_busy && !ld_full;
  assign wr_en    = ld_valid && ld_ready && !ld_start;
  assign q_valid  = (count != 2'd0);
  assign pop      = q_valid && q_ready;
  assign issue    = (state_q == READ) && (rem != '0) && (count < 2'd2);
  assign q_addr   = slot_addr[rd_sel];

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) q[b] = slot[rd_sel][b];
  end

  // rst_done keeps ld_ready low for the cycle in which reset is asserted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_done <= 1'b0;
      lane_ptr <= '0;
      addr_ptr <= '0;
      ld_full  <= FULL_RST;
    end else begin
      rst_done <= 1'b1;
      if (ld_start) begin
        lane_ptr <= '0;
        addr_ptr <= '0;
        ld_full  <= 1'b0;
      end else if (wr_en) begin
        if (lane_ptr == LANE_W'(NUM_BANKS - 1)) begin
          lane_ptr <= '0;
          addr_ptr <= addr_ptr + ADDR_W'(1);
          if (addr_ptr == ADDR_W'(DEPTH - 1)) ld_full <= 1'b1;
        end else begin
          lane_ptr <= lane_ptr + LANE_W'(1);
        end
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (wr_en && (lane_ptr == LANE_W'(b))) mem[addr_ptr] <= ld_data;
    end
    assign mem_out[b] = mem[rd_addr];
  end

  // A zero-length read passes through DRAIN so rd_done lands 2 cycles after rd_start
  always_comb begin
    state_d = state_q;
    rd_done = 1'b0;
    case (state_q)
      IDLE:  if (rd_start) state_d = (rd_len == '0) ? DRAIN : READ;
      READ:  if (issue && (rem == (ADDR_W+1)'(1))) state_d = DRAIN;
      DRAIN: if ((count == 2'd0) || ((count == 2'd1) && pop)) state_d = DONE;
      DONE: begin
        rd_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rd_addr <= '0;
      rem     <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && rd_start) begin
        rd_addr <= rd_base;
        rem     <= rd_len;
      end else if (issue) begin
        rd_addr <= rd_addr + ADDR_W'(1);
        rem     <= rem - (ADDR_W+1)'(1);
      end
    end
  end

  // Read data lands straight in the buffer slot, so the slot doubles as the RAM output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        slot_addr[s] <= '0;
        for (int b = 0; b < NUM_BANKS; b++) slot[s][b] <= '0;
      end
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (issue) begin
        for (int b = 0; b < NUM_BANKS; b++) slot[wr_sel][b] <= mem_out[b];
        slot_addr[wr_sel] <= rd_addr;
        wr_sel <= ~wr_sel;
      end
      if (pop) rd_sel <= ~rd_sel;
      count <= count + {1'b0, issue} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_wb_bank_streamer.sv
// Directed self-checking bench for wb_bank_streamer (default parameters, hex preload disabled).
module tb_wb_bank_streamer;

  localparam int NB = 20;
  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ld_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [DW-1:0] ld_data = '0;
  logic          ld_full;
  logic          rd_start = 1'b0;
  logic [AW-1:0] rd_base = '0;
  logic [AW:0]   rd_len = '0;
  logic          rd_busy;
  logic          rd_done;
  logic          q_valid;
  logic          q_ready = 1'b0;
  logic [DW-1:0] q [NB];
  logic [AW-1:0] q_addr;

  int total = 0;
  int bad = 0;

  wb_bank_streamer dut (
    .clk(clk), .reset(reset),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_full(ld_full),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .rd_busy(rd_busy), .rd_done(rd_done),
    .q_valid(q_valid), .q_ready(q_ready), .q(q), .q_addr(q_addr)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Loaded word k sits in lane k%20 at address k/20
  function automatic logic [DW-1:0] exp_word(int a, int b);
    return DW'(NB * a + b);
  endfunction

  task automatic test_reset;
    #6;
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL reset_ld_ready got=%b want=0", ld_ready); end
    total++; if (ld_full !== 1'b0) begin bad++; $display("FAIL reset_ld_full got=%b want=0", ld_full); end
    total++; if (rd_busy !== 1'b0 || rd_done !== 1'b0) begin bad++; $display("FAIL reset_rd got busy=%b done=%b want 0/0", rd_busy, rd_done); end
    total++; if (q_valid !== 1'b0 || q_addr !== '0 || q[0] !== '0) begin bad++; $display("FAIL reset_q got v=%b a=%0d q0=%0h want 0", q_valid, q_addr, q[0]); end
    step;
    reset = 1'b0;
    step;
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ld_ready got=%b want=1", ld_ready); end
  endtask

  task automatic test_load;
    for (int k = 0; k < NB * 1024; k++) begin
      ld_valid = 1'b1;
      ld_data  = DW'(k);
      if (k == NB * 1024 - 1) begin
        total++; if (ld_full !== 1'b0) begin bad++; $display("FAIL load_full_early got=%b want=0", ld_full); end
      end
      step;
    end
    ld_valid = 1'b0;
    total++; if (ld_full !== 1'b1) begin bad++; $display("FAIL load_full got=%b want=1", ld_full); end
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL load_ready_when_full got=%b want=0", ld_ready); end
  endtask

  task automatic test_basic_read(input int base, input string nm);
    int bl;
    rd_base = AW'(base); rd_len = 11'd4; q_ready = 1'b1; rd_start = 1'b1;
    step;
    rd_start = 1'b0;
    total++; if (rd_busy !== 1'b1 || q_valid !== 1'b0) begin bad++; $display("FAIL %s_cycle1 got busy=%b v=%b want 1/0", nm, rd_busy, q_valid); end
    for (int i = 0; i < 4; i++) begin
      step;
      bl = -1;
      for (int b = 0; b < NB; b++) if (q[b] !== exp_word((base + i) % 1024, b)) bl = b;
      total++;
      if (q_valid !== 1'b1 || q_addr !== AW'((base + i) % 1024) || bl >= 0 || rd_done !== 1'b0) begin
        bad++;
        $display("FAIL %s_vec%0d got v=%b a=%0d lane_err=%0d done=%b want v=1 a=%0d", nm, i, q_valid, q_addr, bl, rd_done, (base + i) % 1024);
      end
    end
    step;
    total++; if (rd_done !== 1'b1 || q_valid !== 1'b0) begin bad++; $display("FAIL %s_done got done=%b v=%b want 1/0", nm, rd_done, q_valid); end
    step;
    total++; if (rd_done !== 1'b0 || rd_busy !== 1'b0) begin bad++; $display("FAIL %s_idle got done=%b busy=%b want 0/0", nm, rd_done, rd_busy); end
  endtask

  task automatic test_len_zero;
    rd_base = 10'd7; rd_len = '0; q_ready = 1'b1; rd_start = 1'b1;
    step;
    rd_start = 1'b0;
    total++; if (rd_done !== 1'b0 || q_valid !== 1'b0) begin bad++; $display("FAIL len0_c1 got done=%b v=%b want 0/0", rd_done, q_valid); end
    step;
    total++; if (rd_done !== 1'b1 || q_valid !== 1'b0) begin bad++; $display("FAIL len0_c2 got done=%b v=%b want 1/0", rd_done, q_valid); end
    step;
    total++; if (rd_done !== 1'b0 || rd_busy !== 1'b0) begin bad++; $display("FAIL len0_c3 got done=%b busy=%b want 0/0", rd_done, rd_busy); end
  endtask

  task automatic test_backpressure;
    int acc = 0;
    logic held = 1'b0;
    logic done_seen = 1'b0;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_q [NB];
    int bl;
    rd_base = 10'd100; rd_len = 11'd8; q_ready = 1'b0; rd_start = 1'b1;
    step;
    rd_start = 1'b0;
    for (int c = 0; c < 80 && !done_seen; c++) begin
      q_ready = (c % 3 == 0);
      if (held) begin
        bl = -1;
        for (int b = 0; b < NB; b++) if (q[b] !== h_q[b]) bl = b;
        total++;
        if (q_valid !== 1'b1 || q_addr !== h_addr || bl >= 0) begin
          bad++; $display("FAIL bp_stable got v=%b a=%0d lane_err=%0d want v=1 a=%0d", q_valid, q_addr, bl, h_addr);
        end
      end
      if (rd_done) done_seen = 1'b1;
      if (q_valid && q_ready) begin
        bl = -1;
        for (int b = 0; b < NB; b++) if (q[b] !== exp_word(100 + acc, b)) bl = b;
        total++;
        if (q_addr !== AW'(100 + acc) || bl >= 0) begin
          bad++; $display("FAIL bp_order got a=%0d lane_err=%0d want a=%0d", q_addr, bl, 100 + acc);
        end
        acc++;
        held = 1'b0;
      end else if (q_valid) begin
        held = 1'b1;
        h_addr = q_addr;
        for (int b = 0; b < NB; b++) h_q[b] = q[b];
      end else begin
        held = 1'b0;
      end
      step;
    end
    total++; if (!done_seen || acc != 8) begin bad++; $display("FAIL bp_count got accepts=%0d done=%b want 8/1", acc, done_seen); end
    q_ready = 1'b1;
  endtask

  task automatic test_reset_mid;
    int bl;
    logic spurious = 1'b0;
    rd_base = '0; rd_len = 11'd10; q_ready = 1'b1; rd_start = 1'b1;
    step;
    rd_start = 1'b0;
    repeat (3) step;
    total++; if (q_addr !== 10'd2 || q_valid !== 1'b1) begin bad++; $display("FAIL rm_third got v=%b a=%0d want 1/2", q_valid, q_addr); end
    step;
    #2 reset = 1'b1;
    #1;
    total++;
    if (q_valid !== 1'b0 || q_addr !== '0 || q[0] !== '0 || q[NB-1] !== '0 || rd_busy !== 1'b0 || rd_done !== 1'b0 || ld_ready !== 1'b0 || ld_full !== 1'b0) begin
      bad++; $display("FAIL rm_outputs got v=%b a=%0d q0=%0h busy=%b done=%b rdy=%b full=%b want all 0", q_valid, q_addr, q[0], rd_busy, rd_done, ld_ready, ld_full);
    end
    step;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (rd_done || q_valid || rd_busy) spurious = 1'b1;
      step;
    end
    total++; if (spurious !== 1'b0) begin bad++; $display("FAIL rm_quiet got activity=%b want 0", spurious); end
    rd_base = '0; rd_len = 11'd2; rd_start = 1'b1;
    step;
    rd_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step;
      bl = -1;
      for (int b = 0; b < NB; b++) if (q[b] !== exp_word(i, b)) bl = b;
      total++;
      if (q_valid !== 1'b1 || q_addr !== AW'(i) || bl >= 0) begin
        bad++; $display("FAIL rm_reread%0d got v=%b a=%0d lane_err=%0d want v=1 a=%0d", i, q_valid, q_addr, bl, i);
      end
    end
    step;
    total++; if (rd_done !== 1'b1) begin bad++; $display("FAIL rm_reread_done got=%b want=1", rd_done); end
    step;
  endtask

  task automatic test_load_busy;
    logic rdy_seen = 1'b0;
    logic done_seen = 1'b0;
    rd_base = 10'd5; rd_len = 11'd3; q_ready = 1'b0; rd_start = 1'b1;
    step;
    rd_start = 1'b0;
    ld_valid = 1'b1; ld_data = 16'hBEEF;
    for (int c = 0; c < 5; c++) begin
      if (ld_ready !== 1'b0) rdy_seen = 1'b1;
      step;
    end
    total++; if (rdy_seen !== 1'b0) begin bad++; $display("FAIL busy_ld_ready got=1 want=0"); end
    ld_valid = 1'b0;
    q_ready = 1'b1;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      if (rd_done) done_seen = 1'b1;
      step;
    end
    total++; if (!done_seen) begin bad++; $display("FAIL busy_done_timeout got=0 want=1"); end
    rd_base = '0; rd_len = 11'd1; rd_start = 1'b1;
    step;
    rd_start = 1'b0;
    step;
    total++; if (q_valid !== 1'b1 || q[0] !== 16'h0000) begin bad++; $display("FAIL busy_no_write got v=%b q0=%0h want 1/0", q_valid, q[0]); end
    step;
    step;
  endtask

  task automatic test_ld_start;
    ld_valid = 1'b1; ld_data = 16'h1111;
    step;
    ld_start = 1'b1; ld_data = 16'h2222;
    step;
    ld_start = 1'b0; ld_data = 16'h3333;
    step;
    ld_data = 16'h4444;
    rd_base = '0; rd_len = 11'd1; q_ready = 1'b1; rd_start = 1'b1;
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL lds_ready_pre got=%b want=1", ld_ready); end
    step;
    ld_valid = 1'b0; rd_start = 1'b0;
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL lds_ready_drop got=%b want=0", ld_ready); end
    step;
    total++;
    if (q_valid !== 1'b1 || q_addr !== '0 || q[0] !== 16'h3333 || q[1] !== 16'h4444 || q[2] !== 16'h0002) begin
      bad++; $display("FAIL lds_data got v=%b a=%0d q0=%0h q1=%0h q2=%0h want 1/0/3333/4444/2", q_valid, q_addr, q[0], q[1], q[2]);
    end
    step;
    total++; if (rd_done !== 1'b1) begin bad++; $display("FAIL lds_done got=%b want=1", rd_done); end
    step;
  endtask

  initial begin
    test_reset;
    test_load;
    test_basic_read(0, "base0");
    test_basic_read(1022, "wrap");
    test_len_zero;
    test_backpressure;
    test_reset_mid;
    test_load_busy;
    test_ld_start;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
